// File: rtl/conv_mem_pkg.sv
// rtl/conv_mem_pkg.sv - shared constants and types for the CONV memory responder
package conv_mem_pkg;

   localparam int MEM_DW       = 20;
   localparam int MEM_AW       = 12;
   localparam int MEM_L0_DEPTH = 4096;
   localparam int MEM_L1_DEPTH = 1024;
   localparam int MEM_CNT_W    = 13;

   localparam logic [2:0] CSEL_L0  = 3'b001;
   localparam logic [2:0] CSEL_L1  = 3'b011;
   localparam logic [2:0] DSEL_IMG = 3'b000;

   typedef enum logic [1:0] {IDLE, REQ, RUN, DONE} state_t;

   // Which bank's registered read data a read-data output is currently showing.
   typedef enum logic [1:0] {SRC_NONE, SRC_IMG, SRC_L0, SRC_L1} rd_src_t;

endpackage

// File: rtl/conv_mem_bank.sv
// rtl/conv_mem_bank.sv - one-write, two-read synchronous RAM bank, read-first
module conv_mem_bank #(
   parameter int DEPTH = 1024,
   parameter int DW    = 20,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re_a,
   input  logic [AW-1:0] raddr_a,
   output logic [DW-1:0] rdata_a,
   input  logic          re_b,
   input  logic [AW-1:0] raddr_b,
   output logic [DW-1:0] rdata_b
);

   logic [DW-1:0] mem [DEPTH];

   // Reads sample the array before this edge's write lands, giving old data on a collision.
   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      if (re_a)
         rdata_a <= mem[raddr_a];
      if (re_b)
         rdata_b <= mem[raddr_b];
   end

endmodule

// File: rtl/conv_mem_resp.sv
// rtl/conv_mem_resp.sv - image and layer memory responder for the CONV accelerator
import conv_mem_pkg::*;

module conv_mem_resp #(
   parameter int DW       = MEM_DW,
   parameter int AW       = MEM_AW,
   parameter int L0_DEPTH = MEM_L0_DEPTH,
   parameter int L1_DEPTH = MEM_L1_DEPTH,
   parameter int CNT_W    = MEM_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             ready,
   input  logic             busy,
   input  logic [AW-1:0]    iaddr,
   output logic [DW-1:0]    idata,
   input  logic             cwr,
   input  logic [AW-1:0]    caddr_wr,
   input  logic [DW-1:0]    cdata_wr,
   input  logic             crd,
   input  logic [AW-1:0]    caddr_rd,
   output logic [DW-1:0]    cdata_rd,
   input  logic [2:0]       csel,
   input  logic             img_we,
   input  logic [AW-1:0]    img_waddr,
   input  logic [DW-1:0]    img_wdata,
   input  logic             dbg_rd,
   input  logic [2:0]       dbg_sel,
   input  logic [AW-1:0]    dbg_addr,
   output logic [DW-1:0]    dbg_data,
   output logic             done,
   output logic [CNT_W-1:0] wr_cnt0,
   output logic [CNT_W-1:0] wr_cnt1,
   output logic             bad_sel
);

   localparam int L0_AW     = $clog2(L0_DEPTH);
   localparam int L1_AW     = $clog2(L1_DEPTH);
   localparam int IMG_DEPTH = 2 ** AW;

   state_t  state, state_nxt;
   rd_src_t cd_src, dbg_src;
   logic    img_vld;

   logic [DW-1:0] img_rd_a, img_rd_b, l0_rd_a, l0_rd_b, l1_rd_a, l1_rd_b;

   logic start_ok, wr_l0, wr_l1, rd_l0, rd_l1, illegal;
   logic dbg_img, dbg_l0, dbg_l1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      done      = 1'b0;
      unique case (state)
         IDLE: if (start) state_nxt = REQ;
         REQ: begin
            ready = 1'b1;
            if (busy) state_nxt = RUN;
         end
         RUN:  if (!busy) state_nxt = DONE;
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // L1 only decodes the low L1_AW address bits; anything above must be zero.
   assign start_ok = start && (state == IDLE);
   assign wr_l0    = cwr && (csel == CSEL_L0);
   assign wr_l1    = cwr && (csel == CSEL_L1) && ((caddr_wr >> L1_AW) == '0);
   assign rd_l0    = crd && (csel == CSEL_L0);
   assign rd_l1    = crd && (csel == CSEL_L1) && ((caddr_rd >> L1_AW) == '0);
   assign illegal  = (cwr && !(wr_l0 || wr_l1)) || (crd && !(rd_l0 || rd_l1));
   assign dbg_img  = dbg_rd && (dbg_sel == DSEL_IMG);
   assign dbg_l0   = dbg_rd && (dbg_sel == CSEL_L0);
   assign dbg_l1   = dbg_rd && (dbg_sel == CSEL_L1) && ((dbg_addr >> L1_AW) == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_cnt0 <= '0;
         wr_cnt1 <= '0;
         bad_sel <= 1'b0;
         cd_src  <= SRC_NONE;
         dbg_src <= SRC_NONE;
         img_vld <= 1'b0;
      end else begin
         img_vld <= (state == RUN);
         if (start_ok) begin
            wr_cnt0 <= '0;
            wr_cnt1 <= '0;
            bad_sel <= 1'b0;
         end else begin
            if (wr_l0 && (wr_cnt0 != '1)) wr_cnt0 <= wr_cnt0 + 1'b1;
            if (wr_l1 && (wr_cnt1 != '1)) wr_cnt1 <= wr_cnt1 + 1'b1;
            if (illegal) bad_sel <= 1'b1;
         end
         if (crd)
            cd_src <= rd_l0 ? SRC_L0 : (rd_l1 ? SRC_L1 : SRC_NONE);
         if (dbg_rd)
            dbg_src <= dbg_img ? SRC_IMG : (dbg_l0 ? SRC_L0 : (dbg_l1 ? SRC_L1 : SRC_NONE));
      end
   end

   // Bank read registers are not reset; the source tags gate them to zero until first use.
   always_comb begin
      idata = img_vld ? img_rd_a : '0;
      unique case (cd_src)
         SRC_L0:  cdata_rd = l0_rd_a;
         SRC_L1:  cdata_rd = l1_rd_a;
         default: cdata_rd = '0;
      endcase
      unique case (dbg_src)
         SRC_IMG: dbg_data = img_rd_b;
         SRC_L0:  dbg_data = l0_rd_b;
         SRC_L1:  dbg_data = l1_rd_b;
         default: dbg_data = '0;
      endcase
   end

   conv_mem_bank #(.DEPTH(IMG_DEPTH), .DW(DW), .AW(AW)) u_img (
      .clk     (clk),
      .we      (img_we && (state == IDLE)),
      .waddr   (img_waddr),
      .wdata   (img_wdata),
      .re_a    (state == RUN),
      .raddr_a (iaddr),
      .rdata_a (img_rd_a),
      .re_b    (dbg_img),
      .raddr_b (dbg_addr),
      .rdata_b (img_rd_b)
   );

   conv_mem_bank #(.DEPTH(L0_DEPTH), .DW(DW), .AW(L0_AW)) u_l0 (
      .clk     (clk),
      .we      (wr_l0),
      .waddr   (caddr_wr[L0_AW-1:0]),
      .wdata   (cdata_wr),
      .re_a    (rd_l0),
      .raddr_a (caddr_rd[L0_AW-1:0]),
      .rdata_a (l0_rd_a),
      .re_b    (dbg_l0),
      .raddr_b (dbg_addr[L0_AW-1:0]),
      .rdata_b (l0_rd_b)
   );

   conv_mem_bank #(.DEPTH(L1_DEPTH), .DW(DW), .AW(L1_AW)) u_l1 (
      .clk     (clk),
      .we      (wr_l1),
      .waddr   (caddr_wr[L1_AW-1:0]),
      .wdata   (cdata_wr),
      .re_a    (rd_l1),
      .raddr_a (caddr_rd[L1_AW-1:0]),
      .rdata_a (l1_rd_a),
      .re_b    (dbg_l1),
      .raddr_b (dbg_addr[L1_AW-1:0]),
      .rdata_b (l1_rd_b)
   );

endmodule

// File: tb/tb_conv_mem_resp.sv
// tb/tb_conv_mem_resp.sv - directed self-checking bench for conv_mem_resp
module tb_conv_mem_resp;

   logic        clk = 1'b0;
   logic        reset, start, busy, cwr, crd, img_we, dbg_rd;
   logic [11:0] iaddr, caddr_wr, caddr_rd, img_waddr, dbg_addr;
   logic [19:0] cdata_wr, img_wdata;
   logic [2:0]  csel, dbg_sel;
   logic        ready, done, bad_sel;
   logic [19:0] idata, cdata_rd, dbg_data;
   logic [12:0] wr_cnt0, wr_cnt1;

   int n_chk  = 0;
   int n_pass = 0;
   int done_cnt;

   typedef struct {
      logic [2:0]  sel;
      logic [11:0] addr;
      logic [19:0] wdata;
      logic [19:0] exp_rd;
      logic        exp_bad;
   } vec_t;

   vec_t vecs[6];

   conv_mem_resp dut (
      .clk(clk), .reset(reset), .start(start), .ready(ready), .busy(busy),
      .iaddr(iaddr), .idata(idata), .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
      .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
      .img_we(img_we), .img_waddr(img_waddr), .img_wdata(img_wdata),
      .dbg_rd(dbg_rd), .dbg_sel(dbg_sel), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
      .done(done), .wr_cnt0(wr_cnt0), .wr_cnt1(wr_cnt1), .bad_sel(bad_sel)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   task automatic dbg_read(input logic [2:0] sel, input logic [11:0] addr);
      dbg_rd = 1'b1; dbg_sel = sel; dbg_addr = addr;
      tick();
      dbg_rd = 1'b0;
   endtask

   task automatic layer_wr(input logic [2:0] sel, input logic [11:0] addr, input logic [19:0] d);
      cwr = 1'b1; csel = sel; caddr_wr = addr; cdata_wr = d;
      tick();
      cwr = 1'b0;
   endtask

   task automatic layer_rd(input logic [2:0] sel, input logic [11:0] addr);
      crd = 1'b1; csel = sel; caddr_rd = addr;
      tick();
      crd = 1'b0;
   endtask

   initial begin
      vecs[0] = '{3'b001, 12'h000, 20'h00001, 20'h00001, 1'b0};
      vecs[1] = '{3'b001, 12'hFFF, 20'h12345, 20'h12345, 1'b0};
      vecs[2] = '{3'b011, 12'h3FF, 20'h54321, 20'h54321, 1'b0};
      vecs[3] = '{3'b011, 12'h000, 20'hFFFFF, 20'hFFFFF, 1'b0};
      vecs[4] = '{3'b011, 12'h400, 20'h11111, 20'h00000, 1'b1};
      vecs[5] = '{3'b010, 12'h005, 20'h22222, 20'h00000, 1'b1};

      reset = 1'b1; start = 1'b0; busy = 1'b0; cwr = 1'b0; crd = 1'b0;
      img_we = 1'b0; dbg_rd = 1'b0; iaddr = '0; caddr_wr = '0; caddr_rd = '0;
      img_waddr = '0; dbg_addr = '0; cdata_wr = '0; img_wdata = '0;
      csel = '0; dbg_sel = '0;
      repeat (3) tick();
      reset = 1'b0;
      tick();

      chk("rst ready", ready, 0);
      chk("rst idata", idata, 0);
      chk("rst cdata_rd", cdata_rd, 0);
      chk("rst dbg_data", dbg_data, 0);
      chk("rst done", done, 0);
      chk("rst wr_cnt0", wr_cnt0, 0);
      chk("rst wr_cnt1", wr_cnt1, 0);
      chk("rst bad_sel", bad_sel, 0);

      for (int i = 0; i < 6; i++) begin
         layer_wr(vecs[i].sel, vecs[i].addr, vecs[i].wdata);
         layer_rd(vecs[i].sel, vecs[i].addr);
         chk($sformatf("vec%0d cdata_rd", i), cdata_rd, vecs[i].exp_rd);
         chk($sformatf("vec%0d bad_sel", i), bad_sel, vecs[i].exp_bad);
      end
      chk("tbl wr_cnt0", wr_cnt0, 2);
      chk("tbl wr_cnt1", wr_cnt1, 2);

      dbg_read(3'b011, 12'h000);
      chk("dbg L1[000] unaliased", dbg_data, 20'hFFFFF);
      dbg_read(3'b001, 12'hFFF);
      chk("dbg L0[FFF]", dbg_data, 20'h12345);
      dbg_read(3'b010, 12'h000);
      chk("dbg bad sel zero", dbg_data, 0);

      layer_rd(3'b001, 12'h000);
      tick();
      chk("cdata_rd hold", cdata_rd, 20'h00001);

      img_we = 1'b1; img_waddr = 12'h005; img_wdata = 20'h0ABCD; tick();
      img_waddr = 12'h006; img_wdata = 20'h00777; tick();
      img_we = 1'b0;
      dbg_read(3'b000, 12'h005);
      chk("dbg IMG[005]", dbg_data, 20'h0ABCD);

      layer_wr(3'b011, 12'h3FF, 20'h00001);
      cwr = 1'b1; crd = 1'b1; csel = 3'b011;
      caddr_wr = 12'h3FF; caddr_rd = 12'h3FF; cdata_wr = 20'h00002;
      tick();
      cwr = 1'b0; crd = 1'b0;
      chk("collision read-first", cdata_rd, 20'h00001);
      layer_rd(3'b011, 12'h3FF);
      chk("collision new data", cdata_rd, 20'h00002);

      start = 1'b1; tick(); start = 1'b0;
      chk("start ready", ready, 1);
      chk("start clr bad_sel", bad_sel, 0);
      chk("start clr wr_cnt0", wr_cnt0, 0);
      chk("start clr wr_cnt1", wr_cnt1, 0);
      img_we = 1'b1; img_waddr = 12'h005; img_wdata = 20'h99999; tick();
      img_we = 1'b0;
      busy = 1'b1; tick();
      chk("busy drops ready", ready, 0);
      iaddr = 12'h005; tick();
      chk("idata IMG[005]", idata, 20'h0ABCD);
      iaddr = 12'h006; tick();
      chk("idata IMG[006]", idata, 20'h00777);

      layer_wr(3'b001, 12'hFFF, 20'h2468A);
      layer_rd(3'b001, 12'hFFF);
      chk("run L0[FFF]", cdata_rd, 20'h2468A);
      chk("run wr_cnt0", wr_cnt0, 1);

      done_cnt = 0;
      for (int c = 0; c < 5000; c++) begin
         iaddr = 12'(c);
         tick();
         if (done) done_cnt++;
      end
      busy = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (done) done_cnt++;
      end
      chk("done pulse count", done_cnt, 1);
      chk("idata after done", idata, 0);
      chk("ready after done", ready, 0);

      start = 1'b1; tick(); start = 1'b0;
      busy = 1'b1; tick(); tick();
      layer_wr(3'b001, 12'h010, 20'h0BEEF);
      chk("midrun wr_cnt0", wr_cnt0, 1);
      #2 reset = 1'b1;
      #1;
      chk("midrun rst ready", ready, 0);
      chk("midrun rst done", done, 0);
      chk("midrun rst wr_cnt0", wr_cnt0, 0);
      @(negedge clk);
      reset = 1'b0; busy = 1'b0;
      done_cnt = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (done) done_cnt++;
      end
      chk("no done after reset", done_cnt, 0);
      dbg_read(3'b001, 12'h010);
      chk("L0 retained", dbg_data, 20'h0BEEF);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/conv_mem_resp.md
Name: conv_mem_resp

Overview:
- Synthesizable responder for the CONV accelerator's memory interfaces.
- Provides the image-source side: ready handshake plus iaddr→idata serving.
- Provides the layer-memory side: cwr/crd/csel with L0 at 4096×20 and L1 at 1024×20.
- Adds a host preload port, a debug readback port and completion tracking.
- Sits beside CONV in FPGA or emulation builds, replacing the behavioural bench memories.

Parameters:
- DW, 20, pixel/data width.
- AW, 12, address width of iaddr, caddr_rd and caddr_wr.
- L0_DEPTH, 4096, layer-0 bank depth.
- L1_DEPTH, 1024, layer-1 bank depth.
- CNT_W, 13, width of the write counters.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high.
- start  in  1  host pulse: begin a run.
- ready  out  1  to CONV: image available.
- busy  in  1  from CONV: run in progress.
- iaddr  in  AW  image address from CONV.
- idata  out  DW  image pixel to CONV.
- cwr  in  1  layer write strobe.
- caddr_wr  in  AW  layer write address.
- cdata_wr  in  DW  layer write data.
- crd  in  1  layer read strobe.
- caddr_rd  in  AW  layer read address.
- cdata_rd  out  DW  layer read data.
- csel  in  3  bank select.
- img_we  in  1  host image preload strobe.
- img_waddr  in  AW  preload address.
- img_wdata  in  DW  preload data.
- dbg_rd  in  1  host readback strobe.
- dbg_sel  in  3  readback bank: 000 image, 001 L0, 011 L1.
- dbg_addr  in  AW  readback address.
- dbg_data  out  DW  readback data.
- done  out  1  one-cycle pulse at end of run.
- wr_cnt0  out  CNT_W  L0 writes this run.
- wr_cnt1  out  CNT_W  L1 writes this run.
- bad_sel  out  1  sticky protocol-error flag.

Behaviour:
- Reset values:
  - Outputs: ready=0, idata=0, cdata_rd=0, dbg_data=0, done=0, wr_cnt0=0, wr_cnt1=0, bad_sel=0.
  - FSM enters IDLE.
  - Memory contents are not reset.
- FSM transitions:
  - IDLE→REQ on start; start also clears wr_cnt0, wr_cnt1 and bad_sel.
  - REQ: ready=1; →RUN on the first cycle busy=1 is sampled.
  - RUN: ready=0; →DONE on the first cycle busy=0 is sampled.
  - DONE: done=1 for exactly one cycle; →IDLE.
  - start outside IDLE is ignored.
- Image serving:
  - In RUN, idata <= IMG[iaddr] on every posedge: 1-cycle latency, a new address every cycle.
  - Outside RUN, idata <= 0.
- Host preload:
  - img_we is honoured only in IDLE: IMG[img_waddr] <= img_wdata.
  - img_we is ignored in every other state.
- Layer memory decode:
  - csel=001 selects L0 (full 12-bit address).
  - csel=011 selects L1; only addresses <1024 are legal.
- Layer writes:
  - cwr=1 with a legal bank/address writes on the posedge.
  - The matching counter increments and saturates at 2^CNT_W−1.
- Layer reads:
  - crd=1 with a legal bank/address: cdata_rd <= bank[addr] on the next posedge (1-cycle latency).
  - When crd=0, cdata_rd holds its previous value.
- Illegal access:
  - Any cwr/crd with another csel value, or with L1 address ≥1024, is illegal.
  - An illegal write is dropped; an illegal read returns 0.
  - Either sets bad_sel, which holds until start or reset.
- Simultaneous cwr+crd:
  - Both are served in the same cycle to the csel bank.
  - If addresses are equal, reads are read-first: the old data is returned.
- Debug readback:
  - Independent port with 1-cycle latency: dbg_data <= bank[dbg_addr] when dbg_rd=1; holds otherwise.
  - Also read-first against a same-cycle write.
  - Any other dbg_sel value returns 0 and does not set bad_sel.
- Reset mid-run: FSM returns to IDLE, ready=0, no done pulse, counters cleared; memory retained.

Decomposition:
- Package conv_mem_pkg holds:
  - CSEL_L0=3'b001, CSEL_L1=3'b011, DSEL_IMG=3'b000.
  - DW, AW and depth constants.
  - State enum {IDLE, REQ, RUN, DONE}.
- Sub-module conv_mem_bank, instantiated three times (IMG, L0, L1):
  - Parameterized depth/width.
  - Two synchronous read ports, read-first.
  - One write port.

Test Plan:
- Handshake and completion:
  - Stimulus: start pulse in IDLE → ready=1 next cycle; CONV raises busy → ready=0 one cycle later; busy falls 5000 cycles later.
  - Response: done pulses exactly once.
- Image serving:
  - Stimulus: preload IMG[0x005]=0x0ABCD, then run with iaddr=0x005.
  - Response: idata=0x0ABCD on the following posedge; idata=0 after DONE.
- L0 write/readback and counting:
  - Stimulus: cwr, csel=001, caddr_wr=0xFFF, cdata_wr=0x12345; next cycle crd to the same address.
  - Response: cdata_rd=0x12345 one cycle later; wr_cnt0=1.
- Read-first on same-cycle collision:
  - Stimulus: L1[0x3FF]=0x00001; then cwr 0x00002 and crd at 0x3FF in the same cycle.
  - Response: cdata_rd=0x00001; the next read returns 0x00002.
- Illegal access handling:
  - Stimulus: cwr with csel=010, then crd with csel=011 and caddr_rd=0x400.
  - Response: bad_sel=1; no memory change; cdata_rd=0; wr counters unchanged; bad_sel cleared by the next start.
- Reset mid-run:
  - Stimulus: assert reset during RUN.
  - Response: ready=0, done=0, counters=0; dbg readback of L0 still returns previously written data.
